// File: rtl/block_pool_compressor.sv
// Raster-stream block downsampler: one rounded-average or max pixel per 2^BLK_LOG2 square block,
// emitted in raster order with a linear address over valid/ready handshakes.
module block_pool_compressor #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned IN_W     = 224,
  parameter int unsigned IN_H     = 224,
  parameter int unsigned BLK_LOG2 = 3,
  parameter int unsigned ROUND    = 1,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              pix_vld,
  input  logic [PIX_W-1:0]  pix_in,
  output logic              pix_rdy,
  output logic              out_vld,
  output logic [PIX_W-1:0]  out_pix,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_rdy,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OUT_W    = IN_W >> BLK_LOG2;
  localparam int unsigned OUT_H    = IN_H >> BLK_LOG2;
  localparam int unsigned N_OUT    = OUT_W * OUT_H;
  localparam int unsigned ACC_W    = PIX_W + 2 * BLK_LOG2;
  localparam int unsigned XW       = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned YW       = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int unsigned BXW      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned BLK_MASK = (1 << BLK_LOG2) - 1;
  localparam int unsigned RND      = (ROUND != 0) ? (1 << (2 * BLK_LOG2 - 1)) : 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic              mode_q;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ACC_W-1:0]  acc [OUT_W];

  logic              accept, out_hs;
  logic              x_last, y_last, frame_last;
  logic              blk_first, blk_last;
  logic [BXW-1:0]    bx;
  logic [ACC_W-1:0]  pix_ext, slot, slot_upd, avg_sum;
  logic [PIX_W-1:0]  blk_val;

  assign pix_rdy    = (state == S_RUN) && (!out_vld || out_rdy);
  assign accept     = pix_vld && pix_rdy;
  assign out_hs     = out_vld && out_rdy;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DRAIN) && out_hs && !start;

  assign x_last     = (x == XW'(IN_W - 1));
  assign y_last     = (y == YW'(IN_H - 1));
  assign frame_last = x_last && y_last;
  assign blk_first  = ((x & XW'(BLK_MASK)) == '0) && ((y & YW'(BLK_MASK)) == '0);
  assign blk_last   = ((x & XW'(BLK_MASK)) == XW'(BLK_MASK)) &&
                      ((y & YW'(BLK_MASK)) == YW'(BLK_MASK));
  assign bx         = BXW'(x >> BLK_LOG2);

  // Column slot update; the block-first pixel reloads the slot left over from the previous block row.
  assign pix_ext = ACC_W'(pix_in);
  assign slot    = acc[bx];

  always_comb begin
    slot_upd = slot + pix_ext;
    if (blk_first) begin
      slot_upd = pix_ext;
    end else if (mode_q) begin
      slot_upd = (pix_ext > slot) ? pix_ext : slot;
    end
  end

  assign avg_sum = slot_upd + ACC_W'(RND);
  assign blk_val = mode_q ? PIX_W'(slot_upd) : PIX_W'(avg_sum >> (2 * BLK_LOG2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_RUN:   if (accept && frame_last) state_nxt = S_DRAIN;
        S_DRAIN: if (out_hs) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Position counters, mode latch and the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      x        <= '0;
      y        <= '0;
      out_vld  <= 1'b0;
      out_pix  <= '0;
      out_addr <= '0;
    end else if (start) begin
      mode_q   <= mode;
      x        <= '0;
      y        <= '0;
      out_vld  <= 1'b0;
      out_pix  <= '0;
      out_addr <= '0;
    end else begin
      if (out_hs) begin
        out_vld <= 1'b0;
        if (out_addr != ADDR_W'(N_OUT - 1)) begin
          out_addr <= out_addr + ADDR_W'(1);
        end
      end
      if (accept) begin
        x <= x_last ? '0 : x + XW'(1);
        if (x_last) begin
          y <= y_last ? '0 : y + YW'(1);
        end
        if (blk_last) begin
          out_vld <= 1'b1;
          out_pix <= blk_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !start) begin
      acc[bx] <= slot_upd;
    end
  end

endmodule

// File: tb/tb_block_pool_compressor.sv
// Scoreboard bench for block_pool_compressor: a 32x32/8x8-block rounding instance and an 8x8/4x4-block
// truncating instance driven with directed frames; a negedge monitor pops expected outputs on each handshake.
module tb_block_pool_compressor;

  localparam int PIX_W = 8;
  localparam int AW = 32, AH = 32, ABLK = 3;
  localparam int BW = 8,  BH = 8,  BBLK = 2;

  typedef struct {
    int addr;
    int pix;
  } exp_t;

  logic clk;
  logic rst_n_a, start_a, mode_a, vld_a, rdy_a, ovld_a, ordy_a, busy_a, done_a;
  logic rst_n_b, start_b, mode_b, vld_b, rdy_b, ovld_b, ordy_b, busy_b, done_b;
  logic [PIX_W-1:0] pix_a, opix_a, pix_b, opix_b;
  logic [3:0] oaddr_a;
  logic [1:0] oaddr_b;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt_a = 0, done_cnt_b = 0;
  int t_first_a = 0, t_done_a = 0, const_val = 0;

  block_pool_compressor #(.PIX_W(PIX_W), .IN_W(AW), .IN_H(AH), .BLK_LOG2(ABLK), .ROUND(1), .ADDR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .mode(mode_a), .pix_vld(vld_a), .pix_in(pix_a),
    .pix_rdy(rdy_a), .out_vld(ovld_a), .out_pix(opix_a), .out_addr(oaddr_a), .out_rdy(ordy_a),
    .busy(busy_a), .done(done_a));

  block_pool_compressor #(.PIX_W(PIX_W), .IN_W(BW), .IN_H(BH), .BLK_LOG2(BBLK), .ROUND(0), .ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .mode(mode_b), .pix_vld(vld_b), .pix_in(pix_b),
    .pix_rdy(rdy_b), .out_vld(ovld_b), .out_pix(opix_b), .out_addr(oaddr_b), .out_rdy(ordy_b),
    .busy(busy_b), .done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix_val(input int kind, input int x, input int y);
    case (kind)
      0:       return const_val;
      1:       return x;
      default: return (x == 9 && y == 17) ? 255 : 10;
    endcase
  endfunction

  // Hand-derived block results: ramp rounds 8bx+3.5 up (A) or truncates 4bx+1.5 down (B).
  function automatic int exp_val(input bit b, input int kind, input int bx, input int by);
    case (kind)
      0:       return const_val;
      1:       return b ? (4 * bx + 1) : (8 * bx + 4);
      default: return (bx == 1 && by == 2) ? 255 : 10;
    endcase
  endfunction

  // Output monitor: each negedge with valid and ready high precedes a handshake edge.
  always @(negedge clk) begin
    if (rst_n_a && !start_a && ovld_a && ordy_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_output: got addr %0d pix %0d, expected none", oaddr_a, opix_a);
      end else begin
        ea = qa.pop_front();
        chk("a_out_addr", int'(oaddr_a), ea.addr);
        chk("a_out_pix", int'(opix_a), ea.pix);
      end
    end
    if (rst_n_b && !start_b && ovld_b && ordy_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_output: got addr %0d pix %0d, expected none", oaddr_b, opix_b);
      end else begin
        eb = qb.pop_front();
        chk("b_out_addr", int'(oaddr_b), eb.addr);
        chk("b_out_pix", int'(opix_b), eb.pix);
      end
    end
    if (done_a) begin
      done_cnt_a++;
      t_done_a = cyc + 1;
    end
    if (done_b) done_cnt_b++;
  end

  task automatic pulse_start(input bit b, input bit m);
    if (b) begin start_b = 1'b1; mode_b = m; qb.delete(); end
    else   begin start_a = 1'b1; mode_a = m; qa.delete(); end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_frame(input bit b, input int kind, input int npix, input bit toggle);
    int w, bs, ow, x, y, g;
    exp_t e;
    w = b ? BW : AW;
    bs = b ? (1 << BBLK) : (1 << ABLK);
    ow = w / bs;
    x = 0;
    y = 0;
    for (int i = 0; i < npix; i++) begin
      if (b) begin
        vld_b = 1'b1; pix_b = PIX_W'(pix_val(kind, x, y));
      end else begin
        vld_a = 1'b1; pix_a = PIX_W'(pix_val(kind, x, y));
        if (toggle) mode_a = ~mode_a;
      end
      g = 0;
      @(negedge clk);
      while (!(b ? rdy_b : rdy_a) && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) begin
        chk("pix_rdy_timeout", 0, 1);
        vld_a = 1'b0; vld_b = 1'b0;
        return;
      end
      if (!b && i == 0) t_first_a = cyc + 1;
      if ((x % bs) == bs - 1 && (y % bs) == bs - 1) begin
        e.addr = (y / bs) * ow + x / bs;
        e.pix  = exp_val(b, kind, x / bs, y / bs);
        if (b) qb.push_back(e); else qa.push_back(e);
      end
      @(posedge clk); #1;
      x++;
      if (x == w) begin x = 0; y++; end
    end
    if (b) vld_b = 1'b0; else vld_a = 1'b0;
  endtask

  task automatic wait_done(input bit b, input int target);
    int g = 0;
    while ((b ? done_cnt_b : done_cnt_a) < target && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (b) begin
      chk("b_done_count", done_cnt_b, target);
      chk("b_queue_left", qb.size(), 0);
    end else begin
      chk("a_done_count", done_cnt_a, target);
      chk("a_queue_left", qa.size(), 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, seen;
    logic [PIX_W-1:0] p0;
    logic [3:0] a0;
    rst_n_a = 0; start_a = 0; mode_a = 0; vld_a = 0; pix_a = '0; ordy_a = 1;
    rst_n_b = 0; start_b = 0; mode_b = 0; vld_b = 0; pix_b = '0; ordy_b = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", int'(ovld_a), 0);
    chk("rst_out_pix", int'(opix_a), 0);
    chk("rst_out_addr", int'(oaddr_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pix_rdy", int'(rdy_a), 0);
    rst_n_a = 1; rst_n_b = 1;
    @(posedge clk); #1;

    // Pixels offered while idle are refused.
    vld_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pix_rdy", int'(rdy_a), 0);
    chk("idle_busy", int'(busy_a), 0);
    @(posedge clk); #1;
    vld_a = 1'b0;

    // Constant frame, full rate.
    const_val = 100;
    pulse_start(0, 0);
    chk("start_pix_rdy", int'(rdy_a), 1);
    send_frame(0, 0, AW * AH, 0);
    chk("drain_busy", int'(busy_a), 1);
    wait_done(0, 1);
    chk("frame_cycles", t_done_a - t_first_a + 1, AW * AH + 1);
    chk("post_done_busy", int'(busy_a), 0);

    // Horizontal ramp with round-half-up.
    pulse_start(0, 0);
    send_frame(0, 1, AW * AH, 0);
    wait_done(0, 2);

    // Max mode with one hot pixel; mode input toggles every pixel.
    pulse_start(0, 1);
    send_frame(0, 2, AW * AH, 1);
    wait_done(0, 3);

    // Backpressure: out_rdy low until 20 cycles after the first output appears.
    ordy_a = 1'b0;
    mode_a = 1'b0;
    pulse_start(0, 0);
    fork
      send_frame(0, 1, AW * AH, 0);
      begin
        g = 0;
        while (!ovld_a && g < 3000) begin
          @(negedge clk);
          g++;
        end
        chk("bp_first_out_seen", int'(ovld_a), 1);
        p0 = opix_a;
        a0 = oaddr_a;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("bp_out_vld_hold", int'(ovld_a), 1);
          chk("bp_out_pix_hold", int'(opix_a), int'(p0));
          chk("bp_out_addr_hold", int'(oaddr_a), int'(a0));
          chk("bp_pix_rdy_low", int'(rdy_a), 0);
        end
        @(posedge clk); #1;
        ordy_a = 1'b1;
      end
    join
    wait_done(0, 4);

    // Abort after 300 pixels, then a full frame of 200s.
    const_val = 50;
    pulse_start(0, 0);
    send_frame(0, 0, 300, 0);
    pulse_start(0, 0);
    const_val = 200;
    send_frame(0, 0, AW * AH, 0);
    wait_done(0, 5);

    // Start while an output is pending discards it without a done pulse.
    const_val = 77;
    ordy_a = 1'b0;
    pulse_start(0, 0);
    send_frame(0, 0, 232, 0);
    chk("pend_out_vld", int'(ovld_a), 1);
    chk("pend_out_pix", int'(opix_a), 77);
    chk("pend_out_addr", int'(oaddr_a), 0);
    pulse_start(0, 0);
    chk("abort_out_vld", int'(ovld_a), 0);
    chk("abort_done_count", done_cnt_a, 5);
    ordy_a = 1'b1;

    // Small instance: truncating ramp, saturated frame, then reset mid-frame.
    pulse_start(1, 0);
    send_frame(1, 1, BW * BH, 0);
    wait_done(1, 1);
    const_val = 255;
    pulse_start(1, 0);
    send_frame(1, 0, BW * BH, 0);
    wait_done(1, 2);

    ordy_b = 1'b0;
    pulse_start(1, 0);
    send_frame(1, 0, 28, 0);
    chk("b_pend_out_vld", int'(ovld_b), 1);
    rst_n_b = 1'b0;
    @(posedge clk); #1;
    chk("b_rst_out_vld", int'(ovld_b), 0);
    chk("b_rst_out_pix", int'(opix_b), 0);
    chk("b_rst_out_addr", int'(oaddr_b), 0);
    chk("b_rst_busy", int'(busy_b), 0);
    chk("b_rst_done", int'(done_b), 0);
    chk("b_rst_pix_rdy", int'(rdy_b), 0);
    rst_n_b = 1'b1;
    qb.delete();
    ordy_b = 1'b1;
    vld_b = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ovld_b || rdy_b) seen++;
    end
    chk("b_quiet_after_reset", seen, 0);
    chk("b_done_after_reset", done_cnt_b, 2);
    vld_b = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_pool_compressor.md
# block_pool_compressor

Parametrised image downsampler. It takes a raster-ordered stream of IN_W×IN_H pixels and emits one pixel per 2^BLK_LOG2 × 2^BLK_LOG2 block: either the rounded average or the maximum of the block. Outputs come in raster order with a linear address. It sits between the frame-buffer DRAM reader and the classifier input SRAM, and uses a valid/ready handshake on both sides so either side can stall.

## Interface
- PIX_W, 8, pixel bit width
- IN_W, 224, input image width in pixels; must be a multiple of 2^BLK_LOG2
- IN_H, 224, input image height in pixels; must be a multiple of 2^BLK_LOG2
- BLK_LOG2, 3, log2 of block side (3 → 8×8 blocks)
- ROUND, 1, 1 = round-half-up average, 0 = truncate
- ADDR_W, 10, output address width; ≥ ceil(log2(OUT_W·OUT_H))
- Derived: OUT_W = IN_W>>BLK_LOG2, OUT_H = IN_H>>BLK_LOG2, ACC_W = PIX_W+2·BLK_LOG2
- clk  in  1  single clock
- rst_n  in  1  reset; synchronous and active-low
- start  in  1  one-cycle pulse; begins a new frame and aborts any frame in progress
- mode  in  1  0 = average, 1 = max; sampled only on start
- pix_vld  in  1  input pixel valid
- pix_in  in  PIX_W  input pixel
- pix_rdy  out  1  block accepts pix_in this cycle
- out_vld  out  1  compressed pixel valid
- out_pix  out  PIX_W  compressed pixel
- out_addr  out  ADDR_W  raster address of out_pix, 0..OUT_W·OUT_H−1
- out_rdy  in  1  downstream accepts output
- busy  out  1  frame in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse when the frame's last output is accepted

## Operation
- **States:** IDLE, RUN, DRAIN.
  - IDLE → RUN on start.
  - RUN → DRAIN when the final pixel (IN_W−1, IN_H−1) is accepted.
  - DRAIN → IDLE when the last output handshakes; done pulses on that same cycle.
  - start in any state → RUN with all counters and the output register cleared.
- **Input acceptance:** a pixel is accepted when pix_vld & pix_rdy.
  - pix_rdy = (state==RUN) & (~out_vld | out_rdy).
  - Input is never accepted in IDLE or DRAIN.
- **Position counters:** internal x (0..IN_W−1) and y (0..IN_H−1) counters advance on each accepted pixel. x wraps to 0 and y increments at IN_W−1.
- **Column storage:** a row of OUT_W accumulators, each ACC_W bits, indexed by bx = x>>BLK_LOG2.
- **Update per accepted pixel:**
  - Block-first pixel (x and y low bits all zero): the slot is loaded with pix_in.
  - Otherwise, average mode: slot += pix_in. Max mode: slot = max(slot, pix_in).
- **Block completion:** on the block-last pixel (x and y low bits all ones), the final value is computed from the updated slot and loaded into the output register:
  - Average: (sum + (ROUND ? 2^(2·BLK_LOG2−1) : 0)) >> 2·BLK_LOG2. This cannot overflow ACC_W.
  - Max: the low PIX_W bits.
  - out_vld is set in the same load.
- **Output address:** out_addr starts at 0 on start and increments by 1 after each output handshake. It is never greater than OUT_W·OUT_H−1.
- **Mode latch:** the mode register holds its value for the whole frame. Changing the mode input mid-frame has no effect.
- **Idle inputs:** pix_vld while in IDLE is ignored.

## Timing
- **Reset values** (synchronous, rst_n low at a clk edge): state = IDLE, out_vld = 0, out_pix = 0, out_addr = 0, busy = 0, done = 0, pix_rdy = 0, x = y = 0. Accumulator contents are don't-care.
- **Start:** pix_rdy can be high from the cycle after start is sampled.
- **Latency:** block-last pixel accepted on edge N → out_vld = 1 with valid out_pix and out_addr after edge N.
- **Output hold:** out_vld, out_pix and out_addr stay stable until out_rdy is high.
- **Full-rate operation:** with out_rdy held high, one pixel is accepted per cycle with no bubbles. A frame takes IN_W·IN_H cycles plus 1 cycle to drain.
- **Simultaneous output handshake and new block completion:** the new value replaces the old one in the same cycle, and out_addr increments.
- **start coinciding with a pending output:** the pending output is discarded (out_vld → 0) and no done pulse is issued for the aborted frame.
- **Reset mid-frame:** the frame is abandoned. Nothing is emitted until the next start.

## Test plan
- **Constant frame:** default params, mode 0, all 50176 pixels = 100, out_rdy = 1 → 784 outputs of 100, addresses 0..783 in order, done pulses once, total 50177 cycles from first accept.
- **Horizontal ramp, rounding:** pix_in = x (0..223), mode 0, ROUND = 1 → out_pix at address a = 8·(a mod 28) + 4. With ROUND = 0 → 8·(a mod 28) + 3.
- **Max mode:** all pixels 10, pixel (x=9, y=17) = 255 → address 57 = 255, all other addresses = 10. Toggling mode mid-frame changes nothing.
- **Backpressure:** out_rdy low for 20 cycles after the first out_vld → pix_rdy low within the same cycle, out_pix and out_addr stable, and no output is lost or duplicated after release.
- **Abort and restart:** start pulsed after 3000 pixels, then a full frame of 200s → no done pulse for the aborted frame, and the new frame gives 784 outputs of 200 starting at address 0.
- **Small parameter set and reset:** IN_W = IN_H = 8, BLK_LOG2 = 2, a 255 frame → 4 outputs of 255. Synchronous rst_n low mid-frame → all outputs return to reset values at the next edge.
